register_file: RTL and testbench

- 32-entry x 32-bit integer register file for the RV32I five-stage pipeline.
- Provides two combinational read ports (rs1/rs2, decode stage) and one synchronous write port (rd, write-back stage).
- Register x0 is hardwired to zero.
- A write-through bypass lets a write-back value be read in the same cycle, so decode sees it without an extra stall.

---
 rtl/register_file.sv | 61 ++++++
 tb/tb_register_file.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, same-cycle write-through bypass.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // x0 has no storage at all, so its read path can never carry X.
  logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];

  logic write_en;
  logic bypass_ok;

  assign write_en  = !rst && WE3 && (A3 != '0);
  assign bypass_ok = !rst && WE3;

  // NOTE: the whole array is cleared on reset, which forces it into flops;
  // a RAM macro cannot be used for this storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        // NOTE: non-blocking assignments for all sequential state, so every
        // register updates from pre-edge values.
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[A3] <= WD3;
    end
  end

  // NOTE: each output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    RD1 = '0;
    if (A1 != '0) begin
      if (bypass_ok && (A3 == A1)) RD1 = WD3;
      else                         RD1 = regs[A1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (A2 != '0) begin
      if (bypass_ok && (A3 == A2)) RD2 = WD3;
      else                         RD2 = regs[A2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: table-driven vectors applied one per
// cycle, expected read data queued at drive time and compared before the edge.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        WE3;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;

  int checks   = 0;
  int failures = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .WE3(WE3),
    .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .RD1(RD1), .RD2(RD2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct packed {
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] wd,
                       input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    rst = r; WE3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd;
    e.e1 = e1;
    e.e2 = e2;
    sb.push_back(e);
  endtask

  task automatic sample(input string name);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got %h/%h expected none", name, RD1, RD2);
    end else begin
      e = sb.pop_front();
      check({name, ".RD1"}, RD1, e.e1);
      check({name, ".RD2"}, RD2, e.e2);
    end
  endtask

  task automatic add(input logic r, input logic we, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] a3, input logic [31:0] wd,
                     input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v = '{rst: r, we: we, a1: a1, a2: a2, a3: a3, wd: wd, e1: e1, e2: e2};
    vecs.push_back(v);
  endtask

  initial begin
    // Table: inputs presented in one cycle, read data expected before that edge.
    //   rst  we    a1  a2  a3  wd            RD1           RD2
    add(1'b0, 1'b1,  1,  0,  1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0);
    add(1'b0, 1'b0,  1,  1,  0, 32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5);
    add(1'b0, 1'b1,  0,  1,  0, 32'hFFFFFFFF, 32'h0,        32'hA5A5A5A5);
    add(1'b0, 1'b0,  0,  0,  0, 32'h0,        32'h0,        32'h0);
    add(1'b0, 1'b1,  0,  1,  2, 32'h12345678, 32'h0,        32'hA5A5A5A5);
    add(1'b0, 1'b0,  2,  1,  0, 32'h0,        32'h12345678, 32'hA5A5A5A5);
    add(1'b0, 1'b0,  2,  2,  0, 32'h0,        32'h12345678, 32'h12345678);
    add(1'b0, 1'b1,  5,  5,  5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    add(1'b0, 1'b0,  5,  3,  0, 32'h0,        32'hDEADBEEF, 32'h0);
    add(1'b0, 1'b1,  7,  6,  7, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0);
    add(1'b0, 1'b1,  7, 31, 31, 32'hCAFEF00D, 32'h0F0F0F0F, 32'hCAFEF00D);
    add(1'b0, 1'b0, 31,  7,  0, 32'h0,        32'hCAFEF00D, 32'h0F0F0F0F);
    add(1'b0, 1'b1,  2,  1,  2, 32'h22222222, 32'h22222222, 32'hA5A5A5A5);
    add(1'b0, 1'b0,  2,  5,  0, 32'h0,        32'h22222222, 32'hDEADBEEF);
    // Reset with a write in flight: no bypass, array still old before the edge.
    add(1'b1, 1'b1,  4,  1,  4, 32'h55AA55AA, 32'h0,        32'hA5A5A5A5);
    add(1'b0, 1'b0,  1,  4,  0, 32'h0,        32'h0,        32'h0);
    add(1'b0, 1'b0,  2, 31,  0, 32'h0,        32'h0,        32'h0);

    // x0 reads zero even before the first reset edge.
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    sample("pre_reset_x0");
    @(posedge clk);

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 32'h0, 32'h0);
      sample($sformatf("reset_sweep[%0d]", i));
    end

    // Bypass visible immediately, withdrawn when WE3 drops before the edge.
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd3, 5'd0, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    sample("bypass_on");
    drive(1'b0, 1'b0, 5'd3, 5'd0, 5'd3, 32'hDEADBEEF, 32'h0, 32'h0);
    sample("bypass_off");
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0);
    sample("x3_unchanged");

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].we, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].wd,
            vecs[i].e1, vecs[i].e2);
      sample($sformatf("vec[%0d]", i));
    end

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
